// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit generate/propagate lookahead adder slice.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat function of g, p and ci; no ripple between bits.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit adder that reuses one 4-bit CLA slice, one nibble per clock,
// with valid/ready handshakes on both sides.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | adding nibble idx, carry held in carry_q
//   DONE  | result presented, waiting for out_ready
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_s;
  logic             slice_co;
  logic [WIDTH-1:0] slice_s_ext;

  assign slice_a     = 4'(a_reg >> (SLICE_W * idx));
  assign slice_b     = 4'(b_reg >> (SLICE_W * idx));
  assign slice_s_ext = WIDTH'(slice_s);

  cla4_slice u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= b;
            carry_q <= cin;
            idx     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          // sum_q is cleared on accept, so OR-ing in each nibble is enough.
          sum_q   <= sum_q | (slice_s_ext << (SLICE_W * idx));
          carry_q <= slice_co;
          idx     <= idx + IDXW'(1);
          if (idx == IDXW'(NSLICE - 1)) begin
            cout_q <= slice_co;
            idx    <= '0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder at WIDTH=16.
module tb_cla_seq_adder;

  localparam int W = 16;
  localparam int LAT = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    return {1'b0, x} + {1'b0, y} + (W + 1)'(ci);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge; returns with the block in RUN.
  task automatic accept(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = xa;
    b = xb;
    cin = xc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("in_ready_after_handoff", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xc, input logic [W-1:0] es, input logic ec);
    int lat;
    accept(xa, xb, xc);
    wait_done(lat);
    check({name, "_latency"}, 32'(lat), 32'(LAT));
    check({name, "_sum"}, 32'(sum), 32'(es));
    check({name, "_cout"}, 32'(cout), 32'(ec));
    handoff();
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_sum"}, 32'(sum), 32'd0);
    check({name, "_cout"}, 32'(cout), 32'd0);
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   exp;
    int           lat;

    vecs[0] = '{a: 16'h0001, b: 16'h0000, cin: 1'b0, s: 16'h0001, c: 1'b0};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, s: 16'h0000, c: 1'b1};
    vecs[2] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, s: 16'hFFFF, c: 1'b1};
    vecs[3] = '{a: 16'h1234, b: 16'h4321, cin: 1'b1, s: 16'h5556, c: 1'b0};
    vecs[4] = '{a: 16'h0F0F, b: 16'h00F1, cin: 1'b0, s: 16'h1000, c: 1'b0};

    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_reset_vals("reset");

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c);

    // Operand changes and in_valid pulses during RUN must not disturb the op.
    accept(16'h1234, 16'h4321, 1'b1);
    for (int k = 0; k < LAT - 1; k++) begin
      check("busy_in_run", 32'(busy), 32'd1);
      check("in_ready_in_run", 32'(in_ready), 32'd0);
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    wait_done(lat);
    check("noise_sum", 32'(sum), 32'h5556);
    check("noise_cout", 32'(cout), 32'd0);
    check("noise_in_ready_done", 32'(in_ready), 32'd0);
    handoff();

    // Backpressure: result must be held while out_ready stays low.
    accept(16'h0B0B, 16'h0606, 1'b0);
    wait_done(lat);
    check("bp_latency", 32'(lat), 32'(LAT));
    for (int k = 0; k < 3; k++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'h1111);
      check("bp_cout", 32'(cout), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_in_ready", 32'(in_ready), 32'd1);
    check("bp_out_valid_dropped", 32'(out_valid), 32'd0);

    // Reset in the middle of RUN takes effect without a clock edge.
    accept(16'hABCD, 16'h1357, 1'b1);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    run_op("after_reset", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

    // Reset while the result is being presented.
    accept(16'h00FF, 16'h0001, 1'b0);
    wait_done(lat);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("donereset");
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if (i == 0) begin ra = 16'h7FFF; rb = 16'h8000; rc = 1'b1; end
      exp = ref_add(ra, rb, rc);
      run_op($sformatf("rand%0d", i), ra, rb, rc, exp[W-1:0], exp[W]);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Multi-cycle adder that adds WIDTH-bit operands using a single 4-bit carry-lookahead slice, one nibble per clock.
- The carry is held in a register between cycles.
- Uses a valid/ready handshake on both input and output sides.
- Lets wide additions share one small CLA datapath instead of instantiating WIDTH/4 slices.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived (localparam), number of slice iterations per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand request
- in_ready  output  1  block can accept operands; high exactly when state is IDLE
- a  input  WIDTH  operand A; sampled only on accept
- b  input  WIDTH  operand B; sampled only on accept
- cin  input  1  carry-in; sampled only on accept
- out_valid  output  1  result available; high exactly when state is DONE
- out_ready  input  1  consumer takes result
- sum  output  WIDTH  registered sum
- cout  output  1  registered carry out of bit WIDTH-1
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, slice index=0, carry reg=0, operand regs=0.
  - sum=0, cout=0, out_valid=0, busy=0.
  - in_ready=1, since it is decoded from IDLE.
- States are IDLE, RUN, DONE.
- IDLE:
  - Accept occurs when in_valid&&in_ready at a rising edge.
  - On accept: capture a, b into operand regs; carry reg<=cin; index<=0; sum<=0; cout<=0; go to RUN.
  - Without in_valid, the state holds.
- RUN, each cycle:
  - The slice adds a_reg[4*idx+:4] + b_reg[4*idx+:4] + carry reg.
  - sum[4*idx+:4] <= slice sum; carry reg <= slice carry-out; idx <= idx+1.
  - When idx==NSLICE-1: cout <= slice carry-out, go to DONE.
- DONE:
  - out_valid=1; sum and cout are held stable.
  - On out_ready, go to IDLE.
  - in_ready=0 in DONE, so a new accept cannot happen in the same cycle as result handoff.
  - The earliest next accept is one cycle after handoff.
- Latency: if accept happens at edge T, out_valid rises after edge T+NSLICE. For WIDTH=16 that is 4 cycles. Throughput is at most one operation per NSLICE+2 cycles.
- Inputs a, b, cin and in_valid are ignored outside IDLE. Operand regs are immune to input changes during RUN.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the true carry out of the MSB. No overflow flag.
- WIDTH=4 is a degenerate case: RUN lasts exactly one cycle.
- Reset mid-RUN or mid-DONE: the block immediately returns to the full reset state. A partial result is never presented.
- Out-of-range idx is not reachable; an illegal state encoding recovers to IDLE.

Decomposition:
- Package cla_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - constant SLICE_W=4
  - function nslice(width) returning width/SLICE_W
- One sub-module, cla4_slice:
  - purely combinational 4-bit generate/propagate lookahead adder.
  - Ports: a[3:0], b[3:0], ci, s[3:0], co.
  - The controller instantiates it once.
- The controller (FSM, index counter, carry/operand/sum regs) stays in cla_seq_adder.

Test Plan:
- Reset: hold rst_n low for 3 cycles, release -> sum=0, cout=0, out_valid=0, busy=0, in_ready=1.
- a=0x0001, b=0x0000, cin=0 -> out_valid after 4 cycles; sum=0x0001, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all 4 iterations; sum=0x0000, cout=1. Also run a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0. During RUN change a/b and pulse in_valid -> result unchanged, in_ready stays 0.
- Backpressure: complete a=0x0B0B, b=0x0606, cin=0, then hold out_ready=0 for 3 cycles -> out_valid held, sum=0x1111 stable, cout=0. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-op: start an op, assert rst_n low after 2 RUN cycles -> outputs return to reset values asynchronously. After release, a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1.
